// File: rtl/caravel_la_core.sv
// Management SoC slice: bus-mapped GPIO pads, 128-bit logic analyzer link and an
// LA-controlled user counter whose state is reflected back on LA_IN.
module caravel_la_core #(
    parameter int unsigned IO_WIDTH  = 38,
    parameter int unsigned LA_WIDTH  = 128,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic                bus_valid,
    input  logic                bus_we,
    input  logic [7:0]          bus_addr,
    input  logic [31:0]         bus_wdata,
    output logic [31:0]         bus_rdata,
    output logic                bus_ready,
    input  logic [IO_WIDTH-1:0] mprj_io_in,
    output logic [IO_WIDTH-1:0] mprj_io_out,
    output logic [IO_WIDTH-1:0] mprj_io_oeb
);
    localparam int unsigned IoHi    = IO_WIDTH - 32;
    localparam int unsigned LaWords = LA_WIDTH / 32;

    logic [IO_WIDTH-1:0]  gpio_out;
    logic [IO_WIDTH-1:0]  gpio_oeb;
    logic [LA_WIDTH-1:0]  la_data;
    logic [LA_WIDTH-1:0]  la_oenb;
    logic [LA_WIDTH-1:0]  la_in;
    logic [CNT_WIDTH-1:0] counter;
    logic [CNT_WIDTH-1:0] counter_next;
    logic [5:0]           word;
    logic [3:0]           region;
    logic [1:0]           la_sel;
    logic                 la_hit;
    logic                 capture;
    logic [31:0]          rd_word;
    logic                 unused_addr;

    assign word        = bus_addr[7:2];
    assign region      = word[5:2];
    assign la_sel      = word[1:0];
    assign la_hit      = 32'(la_sel) < LaWords;
    // A request seen during the acknowledge cycle is the one already served.
    assign capture     = bus_valid && !bus_ready;
    assign unused_addr = ^bus_addr[1:0];

    assign mprj_io_out = gpio_out;
    assign mprj_io_oeb = gpio_oeb;

    always_comb begin
        la_in                  = '0;
        la_in[CNT_WIDTH-1:0]   = counter;
        la_in[64]              = counter >= CNT_WIDTH'(256);
    end

    always_comb begin
        counter_next = counter;
        if (!la_oenb[65] && la_data[65]) begin
            counter_next = '0;
        end else if (la_oenb[CNT_WIDTH-1:0] == '0) begin
            counter_next = la_data[CNT_WIDTH-1:0];
        end else if (!la_oenb[64] && la_data[64]) begin
            counter_next = counter + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        rd_word = '0;
        case (word)
            6'h00:   rd_word = gpio_out[31:0];
            6'h01:   rd_word = 32'(gpio_out[IO_WIDTH-1:32]);
            6'h02:   rd_word = gpio_oeb[31:0];
            6'h03:   rd_word = 32'(gpio_oeb[IO_WIDTH-1:32]);
            6'h04:   rd_word = mprj_io_in[31:0];
            6'h05:   rd_word = 32'(mprj_io_in[IO_WIDTH-1:32]);
            default: begin
                if (la_hit) begin
                    case (region)
                        4'h2:    rd_word = la_data[{la_sel, 5'b0} +: 32];
                        4'h3:    rd_word = la_oenb[{la_sel, 5'b0} +: 32];
                        4'h4:    rd_word = la_in[{la_sel, 5'b0} +: 32];
                        default: rd_word = '0;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            gpio_out  <= '0;
            gpio_oeb  <= '1;
            la_data   <= '0;
            la_oenb   <= '1;
            counter   <= '0;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            counter   <= counter_next;
            bus_ready <= capture;
            bus_rdata <= (capture && !bus_we) ? rd_word : '0;
            if (capture && bus_we) begin
                case (word)
                    6'h00:   gpio_out[31:0]          <= bus_wdata;
                    6'h01:   gpio_out[IO_WIDTH-1:32] <= bus_wdata[IoHi-1:0];
                    6'h02:   gpio_oeb[31:0]          <= bus_wdata;
                    6'h03:   gpio_oeb[IO_WIDTH-1:32] <= bus_wdata[IoHi-1:0];
                    default: begin
                        if (la_hit && region == 4'h2) begin
                            la_data[{la_sel, 5'b0} +: 32] <= bus_wdata;
                        end else if (la_hit && region == 4'h3) begin
                            la_oenb[{la_sel, 5'b0} +: 32] <= bus_wdata;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_caravel_la_core.sv
// Directed plus randomized bus traffic against a word-level model of the register
// file and user counter.
module tb_caravel_la_core;
    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        bus_valid = 1'b0;
    logic        bus_we = 1'b0;
    logic [7:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [37:0] mprj_io_in = '0;
    logic [37:0] mprj_io_out;
    logic [37:0] mprj_io_oeb;

    int checks = 0;
    int failures = 0;

    logic [37:0] gout_m, goeb_m;
    logic [31:0] lad_m [4];
    logic [31:0] lao_m [4];
    logic [31:0] cnt_m;

    caravel_la_core dut (
        .clock       (clock),
        .resetb      (resetb),
        .bus_valid   (bus_valid),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ready   (bus_ready),
        .mprj_io_in  (mprj_io_in),
        .mprj_io_out (mprj_io_out),
        .mprj_io_oeb (mprj_io_oeb)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        gout_m = '0;
        goeb_m = '1;
        for (int i = 0; i < 4; i++) begin
            lad_m[i] = '0;
            lao_m[i] = '1;
        end
        cnt_m = '0;
    endtask

    // One clock of the user counter, from the LA words as they were before the edge.
    task automatic model_tick();
        bit clr, load, inc;
        clr  = (lao_m[2][1] == 1'b0) && (lad_m[2][1] == 1'b1);
        load = (lao_m[0] == 32'd0);
        inc  = (lao_m[2][0] == 1'b0) && (lad_m[2][0] == 1'b1);
        if (clr)       cnt_m = 0;
        else if (load) cnt_m = lad_m[0];
        else if (inc)  cnt_m = cnt_m + 1;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        int w;
        w = int'(a[7:2]);
        if (w == 0)                 gout_m[31:0]  = d;
        else if (w == 1)            gout_m[37:32] = d[5:0];
        else if (w == 2)            goeb_m[31:0]  = d;
        else if (w == 3)            goeb_m[37:32] = d[5:0];
        else if (w >= 8 && w < 12)  lad_m[w-8]    = d;
        else if (w >= 12 && w < 16) lao_m[w-12]   = d;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int w;
        w = int'(a[7:2]);
        if (w == 0)                 return gout_m[31:0];
        if (w == 1)                 return {26'd0, gout_m[37:32]};
        if (w == 2)                 return goeb_m[31:0];
        if (w == 3)                 return {26'd0, goeb_m[37:32]};
        if (w == 4)                 return mprj_io_in[31:0];
        if (w == 5)                 return {26'd0, mprj_io_in[37:32]};
        if (w >= 8 && w < 12)       return lad_m[w-8];
        if (w >= 12 && w < 16)      return lao_m[w-12];
        if (w == 16)                return cnt_m;
        if (w == 18)                return {31'd0, cnt_m >= 32'd256};
        return 32'd0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            model_tick();
        end
    endtask

    task automatic bus_xfer(input bit we, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
        logic [31:0] exp;
        bus_valid = 1'b1;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = d;
        check("ready_before_capture", 64'(bus_ready), 64'd0);
        exp = model_read(a);
        @(posedge clock);
        #1;
        model_tick();
        if (we) model_write(a, d);
        check("ready_after_capture", 64'(bus_ready), 64'd1);
        if (!we) check($sformatf("rdata@%h", a), 64'(bus_rdata), 64'(exp));
        if (we) begin
            check("pad_out", 64'(mprj_io_out), 64'(gout_m));
            check("pad_oeb", 64'(mprj_io_oeb), 64'(goeb_m));
        end
        rd = bus_rdata;
        bus_valid = 1'b0;
        @(posedge clock);
        #1;
        model_tick();
        check("ready_single_pulse", 64'(bus_ready), 64'd0);
    endtask

    logic [31:0] rd;
    logic [7:0]  addrs [21];

    initial begin
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h2C,
                  8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h60, 8'h80,
                  8'hFC};
        model_reset();
        resetb = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        resetb = 1'b1;
        check("reset_oeb", 64'(mprj_io_oeb), 64'h3F_FFFF_FFFF);
        check("reset_out", 64'(mprj_io_out), 64'd0);
        check("reset_ready", 64'(bus_ready), 64'd0);
        bus_xfer(0, 8'h00, 0, rd);  check("reset_rd00", 64'(rd), 64'd0);
        bus_xfer(0, 8'h08, 0, rd);  check("reset_rd08", 64'(rd), 64'hFFFF_FFFF);
        bus_xfer(0, 8'h20, 0, rd);  check("reset_rd20", 64'(rd), 64'd0);
        bus_xfer(0, 8'h40, 0, rd);  check("reset_rd40", 64'(rd), 64'd0);

        bus_xfer(1, 8'h08, 32'h0, rd);
        bus_xfer(1, 8'h00, 32'hAB40_0000, rd);
        check("ckpt_ab40", 64'(mprj_io_out[31:16]), 64'hAB40);
        bus_xfer(1, 8'h00, 32'hAB41_0000, rd);
        check("ckpt_ab41", 64'(mprj_io_out[31:16]), 64'hAB41);

        bus_xfer(1, 8'h30, 32'h0, rd);
        bus_xfer(1, 8'h20, 32'h0000_00F0, rd);
        bus_xfer(1, 8'h30, 32'hFFFF_FFFF, rd);
        bus_xfer(0, 8'h40, 0, rd);  check("la_load_f0", 64'(rd), 64'hF0);

        bus_xfer(1, 8'h38, 32'hFFFF_FFFC, rd);
        bus_xfer(1, 8'h28, 32'h1, rd);
        idle(20);
        bus_xfer(0, 8'h40, 0, rd);  check("cnt_past_milestone", 64'(rd >= 32'h100), 64'd1);
        bus_xfer(0, 8'h48, 0, rd);  check("milestone_flag", 64'(rd[0]), 64'd1);
        bus_xfer(1, 8'h00, 32'hAB51_0000, rd);
        check("ckpt_ab51", 64'(mprj_io_out[31:16]), 64'hAB51);

        bus_xfer(1, 8'h20, 32'hFFFF_FFFF, rd);
        bus_xfer(1, 8'h30, 32'h0, rd);
        bus_xfer(1, 8'h28, 32'h0, rd);
        bus_xfer(1, 8'h30, 32'hFFFF_FFFF, rd);
        bus_xfer(0, 8'h40, 0, rd);  check("preload_ones", 64'(rd), 64'hFFFF_FFFF);
        bus_xfer(1, 8'h28, 32'h1, rd);
        bus_xfer(0, 8'h40, 0, rd);  check("wrap_to_zero", 64'(rd), 64'd0);
        bus_xfer(1, 8'h28, 32'h3, rd);
        bus_xfer(0, 8'h40, 0, rd);  check("clear_wins", 64'(rd), 64'd0);
        idle(5);
        bus_xfer(0, 8'h40, 0, rd);  check("clear_holds", 64'(rd), 64'd0);

        mprj_io_in = 38'h2A_5555_AAAA;
        bus_xfer(0, 8'h10, 0, rd);  check("gpio_in_lo", 64'(rd), 64'h5555_AAAA);
        bus_xfer(0, 8'h14, 0, rd);  check("gpio_in_hi", 64'(rd), 64'h2A);
        bus_xfer(0, 8'h80, 0, rd);  check("unmapped_rd", 64'(rd), 64'd0);

        // Random traffic over mapped and unmapped words, compared against the model.
        for (int n = 0; n < 60; n++) begin
            logic [7:0]  a;
            logic [31:0] lo;
            a  = addrs[$urandom_range(20)];
            lo = $urandom;
            mprj_io_in = {6'($urandom_range(63)), lo};
            bus_xfer(1'($urandom_range(1)), a, $urandom, rd);
            idle(int'($urandom_range(3)));
        end
        bus_xfer(0, 8'h40, 0, rd);
        bus_xfer(0, 8'h48, 0, rd);

        bus_valid = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 8'h00;
        bus_wdata = 32'h1234_5678;
        resetb    = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        check("abort_no_ready", 64'(bus_ready), 64'd0);
        bus_valid = 1'b0;
        @(posedge clock);
        #1;
        resetb = 1'b1;
        check("abort_ready_low", 64'(bus_ready), 64'd0);
        check("abort_out", 64'(mprj_io_out), 64'd0);
        check("abort_oeb", 64'(mprj_io_oeb), 64'h3F_FFFF_FFFF);
        bus_xfer(0, 8'h30, 0, rd);  check("abort_la_oenb", 64'(rd), 64'hFFFF_FFFF);
        bus_xfer(0, 8'h40, 0, rd);  check("abort_counter", 64'(rd), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/caravel_la_core.md
Name: caravel_la_core

Overview:
- Reduced management-SoC slice of the chip.
- Gives the firmware bus access to three things:
  - 38 user I/O pads (output, enable, input readback).
  - A 128-bit logic analyzer (LA) link to the user project.
  - An embedded LA-controlled 32-bit user counter.
- Firmware signals test progress by writing checkpoint codes to pads [31:16], e.g. 0xAB40 (LA test started), 0xAB41, 0xAB51 (LA test 2 passed).

Parameters:
- IO_WIDTH, 38, number of user I/O pads.
- LA_WIDTH, 128, logic analyzer width (multiple of 32).
- CNT_WIDTH, 32, user counter width (at most 64).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetb  in  1  synchronous active-low reset.
- bus_valid  in  1  bus request strobe.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  8  byte address (word aligned; bits [1:0] ignored).
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data; valid while bus_ready = 1.
- bus_ready  out  1  one-cycle acknowledge.
- mprj_io_in  in  IO_WIDTH  pad input values.
- mprj_io_out  out  IO_WIDTH  pad output values.
- mprj_io_oeb  out  IO_WIDTH  pad output enable, active low.

Behaviour:
- Reset: on a rising clock edge with resetb = 0:
  - GPIO_OUT = 0; GPIO_OEB = all 1 (every pad an input).
  - LA_DATA = 0; LA_OENB = all 1; counter = 0.
  - bus_ready = 0; bus_rdata = 0.
- Bus handshake:
  - bus_valid = 1 while bus_ready = 0 is captured; bus_ready pulses high exactly one cycle later (latency 1).
  - A write takes effect on the capture edge, so the new value is visible on outputs in the same cycle bus_ready is high.
  - The master holds bus_valid until it sees bus_ready, then drops it.
  - bus_valid in the ready cycle is ignored, so no back-to-back acknowledge occurs.
  - Reads return a registered snapshot taken at the capture edge.
- Register map (byte offsets):
  - 0x00 GPIO_OUT[31:0] RW; 0x04 GPIO_OUT[37:32] RW in bits [5:0], upper bits read 0.
  - 0x08 GPIO_OEB[31:0] RW; 0x0C GPIO_OEB[37:32] RW.
  - 0x10 GPIO_IN[31:0] RO; 0x14 GPIO_IN[37:32] RO. Both sample mprj_io_in directly with no synchronizer.
  - 0x20–0x2C LA_DATA words 0–3 RW (management to user direction).
  - 0x30–0x3C LA_OENB words 0–3 RW. A bit value of 0 means management drives that LA bit.
  - 0x40–0x4C LA_IN words 0–3 RO (user to management direction).
  - Unmapped reads return 0; unmapped writes are acknowledged and discarded.
- Pads: mprj_io_out = GPIO_OUT and mprj_io_oeb = GPIO_OEB, combinational from the registers.
- User counter, evaluated each cycle in priority order:
  1. LA_OENB[65] = 0 and LA_DATA[65] = 1: counter becomes 0 (clear).
  2. Else if LA_OENB[CNT_WIDTH-1:0] = 0 (all bits management-driven): counter loads LA_DATA[CNT_WIDTH-1:0].
  3. Else if LA_OENB[64] = 0 and LA_DATA[64] = 1: counter increments by 1, wrapping from all-ones to 0.
  4. Else: counter holds.
  - Partial management ownership of bits [CNT_WIDTH-1:0] (some bits 0, some 1) does not trigger the load.
- LA_IN composition:
  - LA_IN[CNT_WIDTH-1:0] = counter.
  - LA_IN[64] = 1 when counter ≥ 0x0000_0100 (milestone flag).
  - All other LA_IN bits are 0.
- A reset asserted mid-transaction aborts it: no acknowledge, and all state returns to reset values.

Test Plan:
1. Apply resetb = 0 for 4 cycles, then release.
   - Expect mprj_io_oeb = all 1 and mprj_io_out = 0.
   - Reading 0x00, 0x08, 0x20, 0x40 returns 0, 0xFFFFFFFF, 0, 0.
2. Write 0x08 = 0x0000_0000, then write 0x00 = 0xAB40_0000.
   - Expect mprj_io_out[31:16] = 0xAB40 and bus_ready exactly 1 cycle after each request.
   - Then write 0xAB41_0000 and expect the pads to read 0xAB41.
3. Write LA_OENB word0 = 0 and LA_DATA word0 = 0x0000_00F0, then set LA_OENB word0 = 0xFFFFFFFF.
   - Expect LA_IN word0 = 0x000000F0.
4. Write LA_OENB word2 = 0xFFFFFFFC and LA_DATA word2 = 0x1 (enable). Wait 20 cycles.
   - Expect LA_IN word0 ≥ 0x100 and LA_IN word2 bit0 = 1.
   - Then write 0xAB51_0000 to GPIO_OUT and expect pads [31:16] = 0xAB51.
5. Preload the counter with 0xFFFFFFFF, then enable increment.
   - Expect 0x00000000 on the next cycle.
   - Set LA_DATA word2 = 0x3 (clear and enable): counter reads 0 and holds there.
6. Drive mprj_io_in = 0x2A_5555_AAAA.
   - Reads: 0x10 = 0x5555AAAA and 0x14 = 0x2A.
   - Read 0x80 (unmapped): returns 0 and is still acknowledged.
   - Assert resetb mid-request: no bus_ready, and registers return to reset values.
